// File: rtl/view_update_ctrl.sv
// View-update sequencer: accumulates pitch/roll/yaw deltas, drives the camera-basis unit and
// presents its result on frame boundaries. Optional build macro: VIEW_PITCH_CLAMP_EN.
module view_update_ctrl #(
    parameter int unsigned ANGLE_W     = 9,
    parameter int unsigned VEC_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned PITCH_MIN   = 0,
    parameter int unsigned PITCH_MAX   = 90
) (
    input  logic                 clk_100mhz,
    input  logic                 rst_in,
    input  logic                 delta_valid,
    input  logic [3:0]           d_pitch,
    input  logic [3:0]           d_roll,
    input  logic [3:0]           d_yaw,
    output logic [ANGLE_W-1:0]   pitch,
    output logic [ANGLE_W-1:0]   roll,
    output logic [ANGLE_W-1:0]   yaw,
    output logic                 basis_start,
    input  logic                 basis_done,
    input  logic [9*VEC_W-1:0]   basis_in,
    input  logic                 frame_sync,
    output logic [9*VEC_W-1:0]   basis_out,
    output logic                 basis_out_valid,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned AW1   = ANGLE_W + 1;
    localparam int unsigned BW    = 9 * VEC_W;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic signed [ANGLE_W:0] FULL_TURN = AW1'(360);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWait
    } state_e;

    state_e state_q, state_d;

    logic [ANGLE_W-1:0] wp_q, wp_d;
    logic [ANGLE_W-1:0] wr_q, wr_d;
    logic [ANGLE_W-1:0] wy_q, wy_d;
    logic [ANGLE_W-1:0] pitch_q, roll_q, yaw_q;
    logic               dirty_q, dirty_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               terr_q, terr_d;
    logic [BW-1:0]      pend_q, pend_d;
    logic               pend_valid_q, pend_valid_d;
    logic [BW-1:0]      out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic               snap_load;
    logic               capture;
    logic               angles_changed;

    // Signed sum of an unsigned angle and a sign-extended 4-bit delta, one bit wider.
    function automatic logic signed [ANGLE_W:0] add_delta(input logic [ANGLE_W-1:0] a,
                                                          input logic [3:0]         d);
        return $signed({1'b0, a}) + $signed({{(ANGLE_W - 3){d[3]}}, d});
    endfunction

    function automatic logic [ANGLE_W-1:0] wrap_add(input logic [ANGLE_W-1:0] a,
                                                    input logic [3:0]         d);
        logic signed [ANGLE_W:0] sum;
        sum = add_delta(a, d);
        if (sum[ANGLE_W]) begin
            sum = sum + FULL_TURN;
        end else if (sum >= FULL_TURN) begin
            sum = sum - FULL_TURN;
        end
        return sum[ANGLE_W-1:0];
    endfunction

`ifdef VIEW_PITCH_CLAMP_EN
    localparam logic signed [ANGLE_W:0] PITCH_LO = AW1'(PITCH_MIN);
    localparam logic signed [ANGLE_W:0] PITCH_HI = AW1'(PITCH_MAX);

    function automatic logic [ANGLE_W-1:0] clamp_add(input logic [ANGLE_W-1:0] a,
                                                     input logic [3:0]         d);
        logic signed [ANGLE_W:0] sum;
        sum = add_delta(a, d);
        if (sum < PITCH_LO) begin
            sum = PITCH_LO;
        end else if (sum > PITCH_HI) begin
            sum = PITCH_HI;
        end
        return sum[ANGLE_W-1:0];
    endfunction
`else
    logic unused_pitch_bounds;
    assign unused_pitch_bounds = ^{PITCH_MIN, PITCH_MAX};
`endif

    // Working-angle accumulation. A request is needed only when some angle really moved,
    // which also covers a clamped pitch that is already sitting on its bound.
    always_comb begin
        wp_d = wp_q;
        wr_d = wr_q;
        wy_d = wy_q;
        if (delta_valid) begin
`ifdef VIEW_PITCH_CLAMP_EN
            wp_d = clamp_add(wp_q, d_pitch);
`else
            wp_d = wrap_add(wp_q, d_pitch);
`endif
            wr_d = wrap_add(wr_q, d_roll);
            wy_d = wrap_add(wy_q, d_yaw);
        end
        angles_changed = (wp_d != wp_q) || (wr_d != wr_q) || (wy_d != wy_q);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dirty_d   = dirty_q;
        terr_d    = terr_q;
        snap_load = 1'b0;
        capture   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (dirty_q) begin
                    state_d   = StStart;
                    dirty_d   = 1'b0;
                    snap_load = 1'b1;
                end
            end
            StStart: begin
                state_d = StWait;
                cnt_d   = '0;
            end
            StWait: begin
                if (basis_done) begin
                    capture = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q == CNT_LAST) begin
                    // Abandon the request and let IDLE retry it.
                    terr_d  = 1'b1;
                    dirty_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A fresh change always outranks the clear on IDLE->START.
        if (angles_changed) begin
            dirty_d = 1'b1;
        end
    end

    // Commit reads pending before this edge's capture; capture then wins on pending_valid.
    always_comb begin
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        out_d        = out_q;
        out_valid_d  = 1'b0;
        if (frame_sync && pend_valid_q) begin
            out_d        = pend_q;
            out_valid_d  = 1'b1;
            pend_valid_d = 1'b0;
        end
        if (capture) begin
            pend_d       = basis_in;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!rst_in) begin
            state_q      <= StIdle;
            wp_q         <= '0;
            wr_q         <= '0;
            wy_q         <= '0;
            pitch_q      <= '0;
            roll_q       <= '0;
            yaw_q        <= '0;
            dirty_q      <= 1'b1;
            cnt_q        <= '0;
            terr_q       <= 1'b0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            wr_q         <= wr_d;
            wy_q         <= wy_d;
            dirty_q      <= dirty_d;
            cnt_q        <= cnt_d;
            terr_q       <= terr_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            if (snap_load) begin
                pitch_q <= wp_q;
                roll_q  <= wr_q;
                yaw_q   <= wy_q;
            end
        end
    end

    assign pitch           = pitch_q;
    assign roll            = roll_q;
    assign yaw             = yaw_q;
    assign basis_start     = (state_q == StStart);
    assign busy            = (state_q != StIdle);
    assign timeout_err     = terr_q;
    assign basis_out       = out_q;
    assign basis_out_valid = out_valid_q;

endmodule

// File: tb/tb_view_update_ctrl.sv
// Scoreboard bench for view_update_ctrl: a behavioural model predicts requests, commits and
// per-cycle status; a monitor compares them as the DUT presents them.
module tb_view_update_ctrl;

    localparam int unsigned ANGLE_W     = 9;
    localparam int unsigned VEC_W       = 32;
    localparam int unsigned TIMEOUT_CYC = 1024;
    localparam int unsigned BW          = 9 * VEC_W;
    localparam int          PITCH_MIN   = 0;
    localparam int          PITCH_MAX   = 90;

    logic               clk_100mhz = 1'b0;
    logic               rst_in = 1'b0;
    logic               delta_valid = 1'b0;
    logic [3:0]         d_pitch = '0;
    logic [3:0]         d_roll = '0;
    logic [3:0]         d_yaw = '0;
    logic [ANGLE_W-1:0] pitch, roll, yaw;
    logic               basis_start;
    logic               basis_done = 1'b0;
    logic [BW-1:0]      basis_in = '0;
    logic               frame_sync = 1'b0;
    logic [BW-1:0]      basis_out;
    logic               basis_out_valid;
    logic               busy;
    logic               timeout_err;

    view_update_ctrl #(
        .ANGLE_W     (ANGLE_W),
        .VEC_W       (VEC_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .PITCH_MIN   (PITCH_MIN),
        .PITCH_MAX   (PITCH_MAX)
    ) dut (
        .clk_100mhz      (clk_100mhz),
        .rst_in          (rst_in),
        .delta_valid     (delta_valid),
        .d_pitch         (d_pitch),
        .d_roll          (d_roll),
        .d_yaw           (d_yaw),
        .pitch           (pitch),
        .roll            (roll),
        .yaw             (yaw),
        .basis_start     (basis_start),
        .basis_done      (basis_done),
        .basis_in        (basis_in),
        .frame_sync      (frame_sync),
        .basis_out       (basis_out),
        .basis_out_valid (basis_out_valid),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int cyc = 0;
    always @(posedge clk_100mhz) cyc <= cyc + 1;

    typedef struct {int cyc; int p; int r; int y;} start_t;
    typedef struct {int cyc; logic [BW-1:0] val;} commit_t;
    typedef struct {int cyc; logic start; logic busy; logic terr; logic bov; int p; int r; int y;} status_t;

    start_t  start_q[$];
    commit_t commit_q[$];
    status_t status_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int n_starts = 0;
    int n_commits = 0;
    int last_start_cyc = 0;

    // Stimulus / responder controls
    logic          rst_req = 1'b0;
    logic          rand_resp = 1'b0;
    logic          fs_with_done = 1'b0;
    int            resp_lat = 5;
    int            due = -1;
    int            last_tick_cyc = 0;
    logic [BW-1:0] last_done_basis = '0;

    // Reference model state: request in flight is identified by the cycle its pulse occupies.
    int            m_ang[3];
    int            m_snap[3];
    bit            m_dirty;
    int            m_req;
    bit            m_terr;
    bit            m_pv;
    logic [BW-1:0] m_pend;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_event(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d: DUT pulsed, model expected nothing", name, cyc);
    endtask

    function automatic int next_angle(input int idx, input int a, input int d);
        int n;
        n = a + d;
`ifdef VIEW_PITCH_CLAMP_EN
        if (idx == 0) begin
            if (n < PITCH_MIN) n = PITCH_MIN;
            if (n > PITCH_MAX) n = PITCH_MAX;
            return n;
        end
`endif
        if (idx > 2) return a;
        return ((n % 360) + 360) % 360;
    endfunction

    function automatic logic [BW-1:0] rand_basis();
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v[i*VEC_W +: VEC_W] = $urandom;
        return v;
    endfunction

    // Predicts what the DUT shows in the cycle after the edge that samples these inputs.
    task automatic model_step(input logic rst, input logic dv, input int dp, input int dr,
                              input int dy, input logic done, input logic [BW-1:0] bin,
                              input logic fs);
        int c;
        int d[3];
        int nv;
        bit commit;
        bit cap;
        status_t s;
        c = cyc;
        commit = 0;
        cap = 0;
        d[0] = dp;
        d[1] = dr;
        d[2] = dy;
        if (!rst) begin
            m_ang = '{0, 0, 0};
            m_snap = '{0, 0, 0};
            m_dirty = 1;
            m_req = -1;
            m_terr = 0;
            m_pv = 0;
            m_pend = '0;
        end else begin
            if (m_req < 0) begin
                if (m_dirty) begin
                    m_req = c + 1;
                    m_snap = m_ang;
                    m_dirty = 0;
                    start_q.push_back('{c + 1, m_ang[0], m_ang[1], m_ang[2]});
                end
            end else if (c > m_req) begin
                if (done) begin
                    cap = 1;
                    m_req = -1;
                end else if (c == m_req + int'(TIMEOUT_CYC)) begin
                    m_terr = 1;
                    m_dirty = 1;
                    m_req = -1;
                end
            end
            if (dv) begin
                for (int i = 0; i < 3; i++) begin
                    nv = next_angle(i, m_ang[i], d[i]);
                    if (nv != m_ang[i]) m_dirty = 1;
                    m_ang[i] = nv;
                end
            end
            if (fs && m_pv) begin
                commit_q.push_back('{c + 1, m_pend});
                m_pv = 0;
                commit = 1;
            end
            if (cap) begin
                m_pend = bin;
                m_pv = 1;
            end
        end
        s = '{c + 1, (m_req == c + 1), (m_req >= 0), m_terr, commit,
              m_snap[0], m_snap[1], m_snap[2]};
        status_q.push_back(s);
    endtask

    // One clock of stimulus; the bench also plays the basis unit, answering each start.
    task automatic tick(input logic dv, input int dp, input int dr, input int dy, input logic fs);
        logic          done_now;
        logic          fs_now;
        logic [BW-1:0] bin;
        int            lat;
        @(negedge clk_100mhz);
        if (!rst_req) begin
            due = -1;
        end else if (basis_start === 1'b1) begin
            if (rand_resp) lat = ($urandom_range(0, 39) == 0) ? 0 : int'($urandom_range(1, 25));
            else lat = resp_lat;
            due = (lat > 0) ? cyc + lat : -1;
        end
        done_now = (due == cyc) || (rand_resp && $urandom_range(0, 63) == 0);
        if (due == cyc) due = -1;
        fs_now = fs || (fs_with_done && done_now);
        bin = rand_basis();
        if (done_now) last_done_basis = bin;
        rst_in = rst_req;
        delta_valid = dv;
        d_pitch = 4'(dp);
        d_roll = 4'(dr);
        d_yaw = 4'(dy);
        basis_done = done_now;
        basis_in = bin;
        frame_sync = fs_now;
        last_tick_cyc = cyc;
        model_step(rst_req, dv, dp, dr, dy, done_now, bin, fs_now);
    endtask

    task automatic run_idle(input int n);
        repeat (n) tick(1'b0, 0, 0, 0, 1'b0);
    endtask

    // Monitor
    always @(negedge clk_100mhz) begin
        status_t s;
        start_t st;
        commit_t cm;
        while (status_q.size() > 0 && status_q[0].cyc < cyc) void'(status_q.pop_front());
        if (status_q.size() > 0 && status_q[0].cyc == cyc) begin
            s = status_q.pop_front();
            check("ctrl{start,busy,terr,bov}", {basis_start, busy, timeout_err, basis_out_valid},
                  {s.start, s.busy, s.terr, s.bov});
            check("snapshot{p,r,y}", {pitch, roll, yaw},
                  {ANGLE_W'(s.p), ANGLE_W'(s.r), ANGLE_W'(s.y)});
        end
        if (basis_start === 1'b1) begin
            n_starts++;
            last_start_cyc = cyc;
            if (start_q.size() == 0) begin
                fail_event("basis_start");
            end else begin
                st = start_q.pop_front();
                check("start_cycle", cyc, st.cyc);
                check("start_angles", {pitch, roll, yaw},
                      {ANGLE_W'(st.p), ANGLE_W'(st.r), ANGLE_W'(st.y)});
            end
        end
        if (basis_out_valid === 1'b1) begin
            n_commits++;
            if (commit_q.size() == 0) begin
                fail_event("basis_out_valid");
            end else begin
                cm = commit_q.pop_front();
                check("commit_cycle", cyc, cm.cyc);
                check("basis_out", basis_out, cm.val);
            end
        end
    end

    initial begin
        int s0;
        int c0;
        int d_cyc;
        logic [BW-1:0] old_b;
        logic [BW-1:0] new_b;

        // Reset, then the post-reset recompute answered after 5 cycles and committed.
        rst_req = 1'b0;
        resp_lat = 5;
        run_idle(3);
        rst_req = 1'b1;
        run_idle(12);
        check("post_reset_starts", n_starts, 1);
        tick(1'b0, 0, 0, 0, 1'b1);
        run_idle(3);
        check("post_reset_commits", n_commits, 1);

        // Yaw wrap in both directions, start two cycles after each idle delta.
        tick(1'b1, 0, 0, -5, 1'b0);
        run_idle(10);
        check("yaw_355", yaw, 355);
        tick(1'b1, 0, 0, 7, 1'b0);
        d_cyc = last_tick_cyc;
        run_idle(10);
        check("yaw_wrap_up", yaw, 2);
        check("latency_up", last_start_cyc - d_cyc, 2);
        tick(1'b1, 0, 0, -8, 1'b0);
        d_cyc = last_tick_cyc;
        run_idle(10);
        check("yaw_wrap_down", yaw, 354);
        check("latency_down", last_start_cyc - d_cyc, 2);

        // Deltas during WAIT collapse into one follow-up request.
        resp_lat = 20;
        s0 = n_starts;
        tick(1'b1, 0, 1, 0, 1'b0);
        run_idle(4);
        repeat (3) tick(1'b1, 0, 0, 1, 1'b0);
        run_idle(50);
        check("wait_deltas_starts", n_starts - s0, 2);
        check("wait_deltas_yaw", yaw, 357);
        check("wait_deltas_roll", roll, 1);

        // Timeout, automatic retry answered normally, then a commit.
        resp_lat = 0;
        s0 = n_starts;
        c0 = n_commits;
        tick(1'b1, 2, 0, 0, 1'b0);
        run_idle(1020);
        resp_lat = 3;
        run_idle(20);
        check("timeout_err", timeout_err, 1);
        check("timeout_retry_starts", n_starts - s0, 2);
        check("busy_after_retry", busy, 0);
        tick(1'b0, 0, 0, 0, 1'b1);
        run_idle(2);
        check("retry_commit", n_commits - c0, 1);

        // frame_sync coinciding with a capture while an older result is pending.
        resp_lat = 4;
        tick(1'b1, 0, 0, 1, 1'b0);
        run_idle(10);
        old_b = last_done_basis;
        c0 = n_commits;
        fs_with_done = 1'b1;
        tick(1'b1, 0, 0, 1, 1'b0);
        run_idle(10);
        fs_with_done = 1'b0;
        new_b = last_done_basis;
        check("coincide_commit_count", n_commits - c0, 1);
        check("coincide_commits_old", basis_out, old_b);
        tick(1'b0, 0, 0, 0, 1'b1);
        run_idle(2);
        check("coincide_commit_new", basis_out, new_b);

`ifdef VIEW_PITCH_CLAMP_EN
        repeat (12) tick(1'b1, 7, 0, 0, 1'b0);
        tick(1'b1, 2, 0, 0, 1'b0);
        run_idle(15);
        check("pitch_88", pitch, 88);
        tick(1'b1, 5, 0, 0, 1'b0);
        run_idle(10);
        check("pitch_clamped", pitch, 90);
        s0 = n_starts;
        tick(1'b1, 3, 0, 0, 1'b0);
        run_idle(10);
        check("clamp_no_start", n_starts - s0, 0);
        check("pitch_held", pitch, 90);
`else
        tick(1'b1, -5, 0, 0, 1'b0);
        run_idle(10);
        check("pitch_wrap", pitch, 357);
`endif

        // Reset in the middle of WAIT.
        resp_lat = 30;
        tick(1'b1, 1, 1, 1, 1'b0);
        run_idle(6);
        rst_req = 1'b0;
        run_idle(2);
        rst_req = 1'b1;
        resp_lat = 3;
        run_idle(15);
        check("rst_mid_wait_terr", timeout_err, 0);
        check("rst_mid_wait_angles", {pitch, roll, yaw}, '0);

        // Randomised traffic.
        rand_resp = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            logic dv;
            int dp, dr, dy;
            dv = ($urandom_range(0, 3) == 0);
            dp = int'($urandom_range(0, 15)) - 8;
            dr = int'($urandom_range(0, 15)) - 8;
            dy = int'($urandom_range(0, 15)) - 8;
            if ($urandom_range(0, 7) == 0) begin
                dp = 0;
                dr = 0;
                dy = 0;
            end
            tick(dv, dp, dr, dy, ($urandom_range(0, 14) == 0));
        end
        rand_resp = 1'b0;
        resp_lat = 3;
        run_idle(1100);
        tick(1'b0, 0, 0, 0, 1'b1);
        run_idle(3);

        check("start_queue_drained", start_q.size(), 0);
        check("commit_queue_drained", commit_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
